// File: rtl/serial_add_sub_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub_if
// Purpose  : Operand/result handshake bundle for the bit-serial adder.
//            master: operand producer and result consumer.
//            slave : the serial_add_sub block.
// Signals  : in_valid/in_ready, a, b, sub       - operand channel
//            out_valid/out_ready, sum, carry    - result channel
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub
// Purpose  : Bit-serial adder/subtractor. One full-adder cell and a
//            registered carry produce one result bit per clock, LSB first.
//            Subtraction feeds ~b with carry-in 1, so carry reads as
//            "no borrow" (A >= B).
// Ports    : clk  - rising-edge clock
//            rst  - synchronous reset, active-high
//            bus  - serial_add_sub_if.slave (operand and result handshakes)
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  wire               clk,
    input  wire               rst,
    serial_add_sub_if.slave   bus
);

    localparam int                c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_c;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_sum_nxt;

    // Ready is masked by rst so nothing can be accepted on a reset edge.
    assign w_in_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Full-adder cell on the current LSBs.
    assign w_s       = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_c       = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
    assign w_sum_nxt = {w_s, r_sum_sh[WIDTH-1:1]};

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.sum       = r_sum;
    assign bus.carry     = r_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)              w_state_nxt = ST_CALC;
            ST_CALC: if (r_cnt == c_LAST)       w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready)         w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a_sh   <= bus.a;
                        r_b_sh   <= bus.sub ? ~bus.b : bus.b;
                        r_c      <= bus.sub;
                        r_sum_sh <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    r_c      <= w_c;
                    r_sum_sh <= w_sum_nxt;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    // Result registers only change on the final bit, so they
                    // stay frozen through DONE and the following IDLE.
                    if (r_cnt == c_LAST) begin
                        r_sum   <= w_sum_nxt;
                        r_carry <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sub
// Purpose  : Self-checking bench for serial_add_sub (WIDTH=8): reset,
//            add/sub vectors, backpressure, mid-operation reset and a
//            randomised regression against a golden model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents one operand pair, then scrambles the
    // operand lines during CALC and waits (bounded) for out_valid.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                          output logic [7:0] s, output logic c, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = a ^ b;
        bus.sub      = ~sub;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        s = bus.sum;
        c = bus.carry;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.sum !== 8'h00 || bus.carry !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h carry=%b, want 0 0 00 0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.carry);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b, want 1", bus.in_ready);
        end
    endtask

    // Directed vector with out_ready=1: checks latency, result and that
    // out_valid drops after exactly one cycle.
    task automatic test_vector(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic sub, input logic [7:0] exp_s, input logic exp_c);
        logic [7:0] s;
        logic       c;
        int         lat;
        bus.out_ready = 1'b1;
        run_op(a, b, sub, s, c, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d edges, want 8", name, lat);
        end
        n_cmp++;
        if (s !== exp_s || c !== exp_c) begin
            n_bad++;
            $display("FAIL %s_result: got sum=%h carry=%b, want sum=%h carry=%b",
                     name, s, c, exp_s, exp_c);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_one_cycle: out_valid=%b in_ready=%b, want 0 1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_add();
        test_vector("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        test_vector("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        test_vector("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_sub();
        test_vector("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        test_vector("sub_07_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
        test_vector("sub_80_80", 8'h80, 8'h80, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [7:0] s;
        logic       c;
        int         lat;
        bus.out_ready = 1'b0;
        run_op(8'h33, 8'h11, 1'b0, s, c, lat);
        n_cmp++;
        if (s !== 8'h44 || c !== 1'b0 || lat !== 8) begin
            n_bad++;
            $display("FAIL bp_result: got sum=%h carry=%b lat=%0d, want 44 0 8", s, c, lat);
        end
        bus.in_valid = 1'b1;
        bus.a        = 8'h01;
        bus.b        = 8'h02;
        bus.sub      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.sum !== 8'h44 || bus.carry !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b sum=%h carry=%b, want 1 0 44 0",
                         i, bus.out_valid, bus.in_ready, bus.sum, bus.carry);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 8'h44) begin
            n_bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b sum=%h, want 0 1 44",
                     bus.out_valid, bus.in_ready, bus.sum);
        end
        run_op(8'h01, 8'h02, 1'b0, s, c, lat);
        n_cmp++;
        if (s !== 8'h03 || c !== 1'b0 || lat !== 8) begin
            n_bad++;
            $display("FAIL bp_next: got sum=%h carry=%b lat=%0d, want 03 0 8", s, c, lat);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic       c;
        int         lat;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'hAA;
        bus.b         = 8'h55;
        bus.sub       = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.sum !== 8'h00 || bus.carry !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_state: in_ready=%b out_valid=%b sum=%h carry=%b, want 1 0 00 0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.carry);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_discard[%0d]: out_valid=%b, want 0", i, bus.out_valid);
            end
        end
        run_op(8'h12, 8'h34, 1'b0, s, c, lat);
        n_cmp++;
        if (s !== 8'h46 || c !== 1'b0 || lat !== 8) begin
            n_bad++;
            $display("FAIL rstmid_next: got sum=%h carry=%b lat=%0d, want 46 0 8", s, c, lat);
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] a, b, s;
        logic       sub, c;
        logic [8:0] exp;
        int         lat, stall;
        for (int k = 0; k < 100; k++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            sub = 1'($urandom);
            exp = {1'b0, a} + (sub ? ({1'b0, ~b} + 9'd1) : {1'b0, b});
            bus.out_ready = 1'b0;
            run_op(a, b, sub, s, c, lat);
            n_cmp++;
            if ({c, s} !== exp || lat !== 8) begin
                n_bad++;
                $display("FAIL rand[%0d] %h%s%h: got carry=%b sum=%h lat=%0d, want carry=%b sum=%h lat=8",
                         k, a, sub ? "-" : "+", b, c, s, lat, exp[8], exp[7:0]);
            end
            stall = $urandom_range(0, 3);
            for (int j = 0; j < stall; j++) begin
                tick();
                n_cmp++;
                if (bus.out_valid !== 1'b1 || {bus.carry, bus.sum} !== exp) begin
                    n_bad++;
                    $display("FAIL rand_stall[%0d]: out_valid=%b carry=%b sum=%h, want 1 %b %h",
                             k, bus.out_valid, bus.carry, bus.sum, exp[8], exp[7:0]);
                end
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial adder/subtractor that computes one result bit per clock using a single full-adder cell and a registered carry. It sits in the arithmetic playground next to the combinational full-adder cells and is their sequential counterpart: it accepts a WIDTH-bit operand pair, ripples through the operands LSB-first over WIDTH cycles, and returns the sum plus carry over a valid/ready handshake. Subtraction uses the same cell, with b inverted and carry-in set to 1.

## Interface
- `WIDTH`, default 8: operand and result width; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `in_valid` input 1: operand pair and `sub` are valid.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: operand A, unsigned.
- `b` input WIDTH: operand B, unsigned.
- `sub` input 1: 0 selects A+B; 1 selects A−B.
- `out_valid` output 1: `sum` and `carry` hold a completed result.
- `out_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: result bits.
- `carry` output 1: for add, the carry-out; for sub, the no-borrow flag (1 when A ≥ B).

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE.
- `in_ready` = (state==IDLE) && !rst. `out_valid` = (state==DONE).
- IDLE, on an edge with in_valid && in_ready:
  - latch a_sh=a and b_sh=(sub ? ~b : b);
  - set c=sub, sum_sh=0, cnt=0;
  - go to CALC.
- CALC, on each edge:
  - s = a_sh[0]^b_sh[0]^c;
  - c = majority(a_sh[0], b_sh[0], c);
  - sum_sh = {s, sum_sh[WIDTH-1:1]};
  - a_sh and b_sh shift right by 1;
  - cnt increments.
  - On the edge where cnt==WIDTH-1: go to DONE and load `sum`=final sum_sh and `carry`=final c.
- DONE: `sum` and `carry` stay stable. On an edge with out_valid && out_ready, go to IDLE. `sum` and `carry` keep their values until the next result is loaded.
- Operand inputs are ignored outside the accept edge. Changing `a`, `b`, or `sub` during CALC has no effect.
- Arithmetic is modulo 2^WIDTH. The result must equal {carry,sum} = a + (sub ? ~b+1 : b) truncated to WIDTH+1 bits, with carry defined as above.
- Internal counter width is $clog2(WIDTH).

## Timing
- Reset values: state=IDLE, `sum`=0, `carry`=0, `out_valid`=0, internal shift registers and counter=0.
- While `rst` is high, `in_ready`=0.
- Latency: `out_valid` rises exactly WIDTH edges after the accepting edge.
- Back-to-back throughput with out_ready held at 1: one operation every WIDTH+2 edges (accept, WIDTH CALC edges, result handshake).
- Backpressure: with out_ready low, the block holds DONE indefinitely. `in_ready` stays 0, and `sum`/`carry` stay frozen.
- Simultaneous events: in_valid is accepted only in IDLE. An out handshake and a new accept never happen on the same edge.
- Reset in any state, including mid-CALC or in DONE with a pending result: the next cycle is IDLE with all outputs at reset values. The partial result is discarded and never presented.
- `out_valid` is not a pulse: it stays high until handshaken.

## Test plan
All scenarios use WIDTH=8.
- Add 8'h0F+8'h01, out_ready=1 → out_valid 8 edges after accept; sum=8'h10, carry=0; out_valid high for exactly one cycle.
- Add 8'hFF+8'h01 → sum=8'h00, carry=1. Add 8'h00+8'h00 → sum=8'h00, carry=0.
- Sub 8'h05−8'h07 → sum=8'hFE, carry=0. Sub 8'h07−8'h05 → sum=8'h02, carry=1. Sub 8'h80−8'h80 → sum=8'h00, carry=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, driving in_valid=1 with new operands → sum/carry/out_valid unchanged and in_ready=0 throughout. After out_ready=1, the block returns to IDLE and then accepts the new pair.
- Reset mid-operation: assert rst for 1 cycle after 3 CALC edges of 8'hAA+8'h55 → next cycle in_ready=1, sum=0, carry=0, out_valid=0. A subsequent 8'h12+8'h34 returns 8'h46, carry=0.
- Random regression: 100 ops with random a, b, sub and random out_ready stalls, compared against the golden model {carry,sum} → zero mismatches. Accept-to-valid latency is always 8 edges.
